// File: rtl/count_ctrl.sv
// count_ctrl: prescaled up/down counter with run/pause/done sequencing for the 2-digit display.
// Latency: number/tc/running update one clock after the accepting edge; tick is combinational.
// Backpressure: none; control pulses are acted on in priority order clear > load > stop > start > tick.
module count_ctrl #(
    parameter int CLK_DIV = 50000000,
    parameter int MAX_VAL = 63,
    parameter int WIDTH   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    input  logic             wrap_en,
    output logic [WIDTH-1:0] number,
    output logic             running,
    output logic             tick,
    output logic             tc
);

    // Prescaler must hold 0..CLK_DIV-1; CLK_DIV is at least 2 so one bit is the floor.
    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VAL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [WIDTH-1:0] number_q, number_d;
    logic             tc_q, tc_d;
    logic             running_q, running_d;

    logic at_top;
    logic at_bot;

    assign at_top = (number_q == MAX_V);
    assign at_bot = (number_q == '0);

    // Step strobe: last prescaler cycle of a period while running.
    assign tick = (state_q == S_RUN) && (pre_q == PRE_LAST);

    assign number  = number_q;
    assign running = running_q;
    assign tc      = tc_q;

    // Next-state: only the highest-priority event acts in a given cycle.
    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        number_d = number_q;
        tc_d     = 1'b0;

        if (clear) begin
            number_d = '0;
            state_d  = S_IDLE;
            pre_d    = '0;
        end else if (load) begin
            // Saturate so the display never sees a value beyond the terminal count.
            number_d = (load_val > MAX_V) ? MAX_V : load_val;
            pre_d    = '0;
            if (state_q == S_DONE) begin
                state_d = S_IDLE;
            end
        end else if (stop && (state_q == S_RUN)) begin
            state_d = S_IDLE;
            pre_d   = '0;
        end else if (start && (state_q == S_IDLE)) begin
            // Prescaler restarts so the first step lands CLK_DIV cycles later.
            state_d = S_RUN;
            pre_d   = '0;
        end else if (state_q == S_RUN) begin
            if (tick) begin
                pre_d = '0;
                // Terminal checks come first, so the +/-1 below can never overflow.
                if (up_dn) begin
                    if (at_top) begin
                        tc_d = 1'b1;
                        if (wrap_en) begin
                            number_d = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        number_d = number_q + WIDTH'(1);
                    end
                end else begin
                    if (at_bot) begin
                        tc_d = 1'b1;
                        if (wrap_en) begin
                            number_d = MAX_V;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        number_d = number_q - WIDTH'(1);
                    end
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end else begin
            // IDLE and DONE keep the prescaler parked at zero.
            pre_d = '0;
        end

        running_d = (state_d == S_RUN);
    end

    // State, count and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pre_q     <= '0;
            number_q  <= '0;
            tc_q      <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            number_q  <= number_d;
            tc_q      <= tc_d;
            running_q <= running_d;
        end
    end

endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: directed scenarios plus randomized pulses against an integer reference model.
// Latency: checks sample on the falling edge, after the rising edge that updates the DUT.
// Backpressure: none; stimulus changes on the falling edge only.
module tb_count_ctrl;

    localparam int CDIV = 4;
    localparam int MAXV = 63;
    localparam int W    = 7;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, stop, clear, load;
    logic [W-1:0] load_val;
    logic         up_dn, wrap_en;
    logic [W-1:0] number;
    logic         running, tick, tc;

    int errors = 0;
    int checks = 0;

    count_ctrl #(.CLK_DIV(CDIV), .MAX_VAL(MAXV), .WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .up_dn    (up_dn),
        .wrap_en  (wrap_en),
        .number   (number),
        .running  (running),
        .tick     (tick),
        .tc       (tc)
    );

    always #5 clk = ~clk;

    // Reference model: mode, integer count, and cycles elapsed since the period restarted.
    int m_num, m_mode, m_age;
    bit m_tc;
    bit m_tick;
    int n_num, n_mode, n_age;
    bit n_tc;

    assign m_tick = (m_mode == M_RUN) && ((m_age % CDIV) == CDIV - 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_num  <= 0;
            m_mode <= M_IDLE;
            m_age  <= 0;
            m_tc   <= 1'b0;
        end else begin
            n_num  = m_num;
            n_mode = m_mode;
            n_age  = m_age;
            n_tc   = 1'b0;
            if (clear) begin
                n_num  = 0;
                n_mode = M_IDLE;
            end else if (load) begin
                n_num = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
                n_age = 0;
                if (n_mode == M_DONE) n_mode = M_IDLE;
            end else if (stop && m_mode == M_RUN) begin
                n_mode = M_IDLE;
            end else if (start && m_mode == M_IDLE) begin
                n_mode = M_RUN;
                n_age  = 0;
            end else if (m_mode == M_RUN) begin
                if (m_tick) begin
                    n_num = up_dn ? m_num + 1 : m_num - 1;
                    if (n_num > MAXV || n_num < 0) begin
                        n_tc = 1'b1;
                        if (wrap_en) n_num = up_dn ? 0 : MAXV;
                        else begin
                            n_num  = m_num;
                            n_mode = M_DONE;
                        end
                    end
                end
                n_age = m_age + 1;
            end
            m_num  <= n_num;
            m_mode <= n_mode;
            m_age  <= n_age;
            m_tc   <= n_tc;
        end
    end

    // Drive a set of one-cycle pulses; returns on the falling edge after the accepting edge.
    task automatic pulse_sig(input logic s_start, input logic s_stop, input logic s_clear, input logic s_load);
        start = s_start; stop = s_stop; clear = s_clear; load = s_load;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 0; stop = 0; clear = 0; load = 0; load_val = '0; up_dn = 1; wrap_en = 0;
        #3;
        checks++; if (number !== 7'd0) begin errors++; $display("FAIL reset_number got=%0d exp=0", number); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got=%b exp=0", tc); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(2);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_idle_running got=%b exp=0", running); end
    endtask

    task automatic test_count_up();
        logic [W-1:0] e;
        up_dn = 1; wrap_en = 0;
        pulse_sig(1, 0, 0, 0);
        for (int k = 0; k <= 12; k++) begin
            e = W'(k / 4);
            checks++; if (number !== e) begin errors++; $display("FAIL up_number k=%0d got=%0d exp=%0d", k, number, e); end
            checks++; if (tick !== (k % 4 == 3)) begin errors++; $display("FAIL up_tick k=%0d got=%b exp=%b", k, tick, (k % 4 == 3)); end
            checks++; if (running !== 1'b1) begin errors++; $display("FAIL up_running k=%0d got=%b exp=1", k, running); end
            checks++; if (tc !== 1'b0) begin errors++; $display("FAIL up_tc k=%0d got=%b exp=0", k, tc); end
            if (k < 12) @(negedge clk);
        end
        pulse_sig(0, 1, 0, 0);
        checks++; if (running !== 1'b0 || number !== 7'd3) begin errors++; $display("FAIL up_stop running=%b number=%0d exp 0/3", running, number); end
        pulse_sig(0, 0, 1, 0);
    endtask

    task automatic test_terminal_stop();
        load_val = 7'd62; up_dn = 1; wrap_en = 0;
        pulse_sig(0, 0, 0, 1);
        checks++; if (number !== 7'd62) begin errors++; $display("FAIL term_load got=%0d exp=62", number); end
        pulse_sig(1, 0, 0, 0);
        wait_cyc(4);
        checks++; if (number !== 7'd63 || tc !== 1'b0) begin errors++; $display("FAIL term_step1 number=%0d tc=%b exp 63/0", number, tc); end
        wait_cyc(4);
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL term_tc got=%b exp=1", tc); end
        checks++; if (number !== 7'd63 || running !== 1'b0) begin errors++; $display("FAIL term_done number=%0d running=%b exp 63/0", number, running); end
        @(negedge clk);
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL term_tc_width got=%b exp=0", tc); end
        pulse_sig(1, 0, 0, 0);
        wait_cyc(8);
        checks++; if (running !== 1'b0 || number !== 7'd63) begin errors++; $display("FAIL term_start_ignored running=%b number=%0d exp 0/63", running, number); end
        pulse_sig(0, 0, 1, 0);
        checks++; if (number !== 7'd0 || running !== 1'b0) begin errors++; $display("FAIL term_clear number=%0d running=%b exp 0/0", number, running); end
    endtask

    task automatic test_wrap_down();
        load_val = 7'd0; up_dn = 0; wrap_en = 1;
        pulse_sig(0, 0, 0, 1);
        pulse_sig(1, 0, 0, 0);
        wait_cyc(4);
        checks++; if (number !== 7'd63 || tc !== 1'b1) begin errors++; $display("FAIL wrap_number number=%0d tc=%b exp 63/1", number, tc); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL wrap_running got=%b exp=1", running); end
        @(negedge clk);
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL wrap_tc_width got=%b exp=0", tc); end
        wait_cyc(3);
        checks++; if (number !== 7'd62) begin errors++; $display("FAIL wrap_next got=%0d exp=62", number); end
        pulse_sig(0, 1, 0, 0);
        pulse_sig(0, 0, 1, 0);
    endtask

    task automatic test_load_sat_clear();
        load_val = 7'd70;
        pulse_sig(0, 0, 0, 1);
        checks++; if (number !== 7'd63) begin errors++; $display("FAIL load_sat got=%0d exp=63", number); end
        pulse_sig(1, 0, 0, 0);
        wait_cyc(1);
        load_val = 7'd5;
        pulse_sig(0, 0, 1, 1);
        checks++; if (number !== 7'd0 || running !== 1'b0) begin errors++; $display("FAIL clear_over_load number=%0d running=%b exp 0/0", number, running); end
        wait_cyc(4);
        checks++; if (number !== 7'd0 || running !== 1'b0) begin errors++; $display("FAIL clear_idle number=%0d running=%b exp 0/0", number, running); end
    endtask

    task automatic test_stop_resume();
        up_dn = 1; wrap_en = 0;
        pulse_sig(1, 0, 0, 0);
        wait_cyc(5);
        checks++; if (number !== 7'd1) begin errors++; $display("FAIL pause_pre got=%0d exp=1", number); end
        pulse_sig(0, 1, 0, 0);
        checks++; if (running !== 1'b0 || number !== 7'd1) begin errors++; $display("FAIL pause_stop running=%b number=%0d exp 0/1", running, number); end
        wait_cyc(3);
        checks++; if (number !== 7'd1 || tick !== 1'b0) begin errors++; $display("FAIL pause_hold number=%0d tick=%b exp 1/0", number, tick); end
        pulse_sig(1, 0, 0, 0);
        wait_cyc(3);
        checks++; if (tick !== 1'b1 || number !== 7'd1) begin errors++; $display("FAIL resume_tick tick=%b number=%0d exp 1/1", tick, number); end
        @(negedge clk);
        checks++; if (number !== 7'd2) begin errors++; $display("FAIL resume_step got=%0d exp=2", number); end
        wait_cyc(3);
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL stop_tick_pre got=%b exp=1", tick); end
        pulse_sig(0, 1, 0, 0);
        checks++; if (number !== 7'd2 || tc !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL stop_on_tick number=%0d tc=%b running=%b exp 2/0/0", number, tc, running); end
        pulse_sig(0, 0, 1, 0);
    endtask

    task automatic test_async_reset();
        load_val = 7'd37;
        pulse_sig(0, 0, 0, 1);
        pulse_sig(1, 0, 0, 0);
        wait_cyc(2);
        checks++; if (number !== 7'd37 || running !== 1'b1) begin errors++; $display("FAIL arst_pre number=%0d running=%b exp 37/1", number, running); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (number !== 7'd0 || running !== 1'b0 || tc !== 1'b0 || tick !== 1'b0) begin
            errors++; $display("FAIL arst_async number=%0d running=%b tc=%b tick=%b exp 0/0/0/0", number, running, tc, tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(6);
        checks++; if (number !== 7'd0 || running !== 1'b0) begin errors++; $display("FAIL arst_idle number=%0d running=%b exp 0/0", number, running); end
        pulse_sig(1, 0, 0, 0);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL arst_restart got=%b exp=1", running); end
        pulse_sig(0, 0, 1, 0);
    endtask

    task automatic test_random();
        logic [W-1:0] ends_tab [6];
        ends_tab[0] = 7'd0;  ends_tab[1] = 7'd1;  ends_tab[2] = 7'd62;
        ends_tab[3] = 7'd63; ends_tab[4] = 7'd70; ends_tab[5] = 7'd127;
        for (int c = 0; c < 3000; c++) begin
            checks++; if (number !== W'(m_num)) begin errors++; $display("FAIL rand_number cyc=%0d got=%0d exp=%0d", c, number, m_num); end
            checks++; if (running !== (m_mode == M_RUN)) begin errors++; $display("FAIL rand_running cyc=%0d got=%b exp=%b", c, running, (m_mode == M_RUN)); end
            checks++; if (tick !== m_tick) begin errors++; $display("FAIL rand_tick cyc=%0d got=%b exp=%b", c, tick, m_tick); end
            checks++; if (tc !== m_tc) begin errors++; $display("FAIL rand_tc cyc=%0d got=%b exp=%b", c, tc, m_tc); end
            clear = ($urandom_range(0, 99) < 2);
            load  = ($urandom_range(0, 99) < 4);
            stop  = ($urandom_range(0, 99) < 5);
            start = ($urandom_range(0, 99) < 15);
            load_val = ($urandom_range(0, 1) == 1) ? ends_tab[$urandom_range(0, 5)] : W'($urandom_range(0, 127));
            if ($urandom_range(0, 15) == 0) up_dn = 1'($urandom);
            if ($urandom_range(0, 15) == 0) wrap_en = 1'($urandom);
            @(negedge clk);
        end
        start = 0; stop = 0; clear = 0; load = 0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_terminal_stop();
        test_wrap_down();
        test_load_sat_clear();
        test_stop_resume();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
